// File: rtl/sub_pkg.sv
// Shared definitions for the byte-serial subtractor: FSM encoding and slice width.
package sub_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder slice: sum_o = a_i + b_i + cin_i, carry-out on cout_o.
module cla_8bit
    import sub_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    input  logic              cin_i,
    output logic [BYTE_W-1:0] sum_o,
    output logic              cout_o
);

    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] p;
    logic [BYTE_W:0]   c;
    logic              pp;

    // Each carry is formed directly from generate/propagate terms (flat lookahead, no ripple).
    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c    = '0;
        pp   = 1'b0;
        c[0] = cin_i;
        for (int i = 0; i < BYTE_W; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin_i);
        end
    end

    assign sum_o  = p ^ c[BYTE_W-1:0];
    assign cout_o = c[BYTE_W];

endmodule

// File: rtl/sub_32bit_seq.sv
// Byte-serial two's-complement subtractor: d = a - b, one byte per clock through a
// single 8-bit lookahead slice, with borrow/overflow/zero flags and valid/ready on both sides.
module sub_32bit_seq
    import sub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int NBYTES = WIDTH / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    // res_q accumulates bytes privately so the visible d never shows a partial result.
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [BYTE_W-1:0] a_byte;
    logic [BYTE_W-1:0] b_byte;
    logic [BYTE_W-1:0] d_byte;
    logic              c_byte;
    logic [WIDTH-1:0]  res_next;

    assign a_byte = a_q[int'(idx_q)*BYTE_W +: BYTE_W];
    assign b_byte = b_q[int'(idx_q)*BYTE_W +: BYTE_W];

    cla_8bit u_cla (
        .a_i    (a_byte),
        .b_i    (~b_byte),
        .cin_i  (carry_q),
        .sum_o  (d_byte),
        .cout_o (c_byte)
    );

    // Merge the byte just computed into the accumulated difference.
    always_comb begin
        res_next = res_q;
        res_next[int'(idx_q)*BYTE_W +: BYTE_W] = d_byte;
    end

    // FSM next state plus operand, byte-counter, result and flag updates.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        res_d    = res_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                res_d   = res_next;
                carry_d = c_byte;
                if (idx_q == LAST_IDX) begin
                    state_d  = S_DONE;
                    d_d      = res_next;
                    borrow_d = ~c_byte;
                    ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                               (res_next[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d   = (res_next == '0);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            res_q    <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            res_q    <= res_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign d         = d_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_sub_32bit_seq.sv
// Bench for sub_32bit_seq: directed and random operands, scoreboard of expected results.
module tb_sub_32bit_seq;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] d;
        logic         borrow;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] d;
    logic         borrow;
    logic         ovf;
    logic         zero;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t sb[$];

    sub_32bit_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.d      = x - y;
        e.borrow = (x < y);
        e.ovf    = ($signed(x) - $signed(y) > 64'sh7FFF_FFFF) ||
                   ($signed(x) - $signed(y) < -64'sh8000_0000);
        e.zero   = (x == y);
        return e;
    endfunction

    // Present operands at a negedge and hold until accepted; push the expected result.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        a = x;
        b = y;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        sb.push_back(model(x, y));
        @(negedge clk);
        acc_cyc = cyc;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Wait for out_valid, check latency and result, then hand-shake it out.
    task automatic recv(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 0, 1);
            return;
        end
        check({tag, "_lat"}, 64'(cyc - acc_cyc), 64'd4);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_d"}, 64'(d), 64'(e.d));
        check({tag, "_flags"}, 64'({borrow, ovf, zero}), 64'({e.borrow, e.ovf, e.zero}));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_hold_d"}, 64'(d), 64'(e.d));
    endtask

    initial begin
        exp_t e;
        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_d", 64'(d), 64'd0);
        check("rst_flags", 64'({borrow, ovf, zero}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // out_ready while idle is ignored
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_oready_ovalid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        send(32'h0000_0005, 32'h0000_0003); recv("t1");
        send(32'h0001_0000, 32'h0000_0001); recv("t2a");
        send(32'h0000_0000, 32'h0000_0001); recv("t2b");
        send(32'h8000_0000, 32'h0000_0001); recv("t3a");
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF); recv("t3b");
        send(32'h1234_5678, 32'h1234_5678); recv("t4");
        for (int i = 0; i < 8; i++) begin
            send($urandom, $urandom);
            recv("rnd");
        end

        // Back-pressure in DONE with new operands offered
        send(32'h0000_00F0, 32'h0000_0FFF);
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        e = sb.pop_front();
        in_valid = 1'b1;
        a = 32'hDEAD_BEEF;
        b = 32'h0000_1111;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_d", 64'(d), 64'(e.d));
            check("bp_flags", 64'({borrow, ovf, zero}), 64'({e.borrow, e.ovf, e.zero}));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        check("bp_release_d", 64'(d), 64'(e.d));
        @(posedge clk);
        sb.push_back(model(32'hDEAD_BEEF, 32'h0000_1111));
        @(negedge clk);
        acc_cyc = cyc;
        in_valid = 1'b0;
        recv("bp_next");

        // Reset during the second CALC cycle
        send(32'h0000_0100, 32'h0000_0001);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_d", 64'(d), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        send(32'd10, 32'd4); recv("t6");
        check("t6_sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
